// File: rtl/fp_mul_pipe.sv
// Pipelined floating-point multiplier with generic exponent/fraction widths,
// flush-to-zero subnormals, five rounding modes and a valid/ready handshake.
module fp_mul_pipe #(
    parameter int EXP_W  = 8,
    parameter int FRC_W  = 23,
    parameter int STAGES = 3,
    parameter int TAG_W  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+FRC_W:0]   fp_X,
    input  logic [EXP_W+FRC_W:0]   fp_Y,
    input  logic [2:0]             r_mode,
    input  logic [TAG_W-1:0]       in_tag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+FRC_W:0]   fp_Z,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   ovrf,
    output logic                   udrf,
    output logic                   zer,
    output logic                   inf,
    output logic                   nan
);
    localparam int W  = 1 + EXP_W + FRC_W;
    localparam int PW = 2 * FRC_W + 2;
    localparam int EW = EXP_W + 2;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    function automatic logic round_inc(input logic [2:0] rm, input logic sgn,
                                       input logic lsb, input logic g, input logic s);
        case (rm)
            3'b001:  round_inc = 1'b0;
            3'b010:  round_inc = sgn & (g | s);
            3'b011:  round_inc = ~sgn & (g | s);
            3'b100:  round_inc = g;
            default: round_inc = g & (s | lsb);
        endcase
    endfunction

    // Returns {ovrf, udrf, word}; out-of-range exponents saturate to inf or signed zero.
    function automatic logic [W+1:0] saturate(input logic signed [EW-1:0] e, input logic sgn,
                                              input logic [FRC_W-1:0] frac);
        if (!e[EW-1] && e >= EMAX)
            saturate = {2'b10, sgn, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
        else if (e[EW-1] || e == '0)
            saturate = {2'b01, sgn, {(EXP_W + FRC_W){1'b0}}};
        else
            saturate = {2'b00, sgn, e[EXP_W-1:0], frac};
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // ---- operand boundary (registered only in the 4-stage build)
    logic [W-1:0]     x_p0, y_p0;
    logic [2:0]       rm_p0;
    logic [TAG_W-1:0] tag_p0;
    logic             vld_p0;

    generate
        if (STAGES >= 4) begin : g_p0_reg
            always_ff @(posedge clk) begin
                if (rst)     vld_p0 <= 1'b0;
                else if (en) vld_p0 <= in_valid;
            end
            always_ff @(posedge clk) begin
                if (en && in_valid) begin
                    x_p0   <= fp_X;
                    y_p0   <= fp_Y;
                    rm_p0  <= r_mode;
                    tag_p0 <= in_tag;
                end
            end
        end else begin : g_p0_wire
            assign vld_p0 = in_valid;
            assign x_p0   = fp_X;
            assign y_p0   = fp_Y;
            assign rm_p0  = r_mode;
            assign tag_p0 = in_tag;
        end
    endgenerate

    logic [EXP_W-1:0]       ex_a, ey_a;
    logic [FRC_W-1:0]       fx_a, fy_a;
    logic                   xz_a, yz_a, xi_a, yi_a, xn_a, yn_a;
    logic                   sgn_a, nan_a, inf_a, zer_a;
    logic signed [EW-1:0]   esum_a;
    logic [PW-1:0]          prod_a;

    always_comb begin
        ex_a   = x_p0[W-2:FRC_W];
        ey_a   = y_p0[W-2:FRC_W];
        fx_a   = x_p0[FRC_W-1:0];
        fy_a   = y_p0[FRC_W-1:0];
        xz_a   = (ex_a == '0);
        yz_a   = (ey_a == '0);
        xi_a   = (ex_a == '1) && (fx_a == '0);
        yi_a   = (ey_a == '1) && (fy_a == '0);
        xn_a   = (ex_a == '1) && (fx_a != '0);
        yn_a   = (ey_a == '1) && (fy_a != '0);
        sgn_a  = x_p0[W-1] ^ y_p0[W-1];
        nan_a  = xn_a || yn_a || (xi_a && yz_a) || (yi_a && xz_a);
        inf_a  = xi_a || yi_a;
        zer_a  = xz_a || yz_a;
        esum_a = $signed({2'b00, ex_a}) + $signed({2'b00, ey_a}) - BIAS;
        prod_a = PW'({1'b1, fx_a}) * PW'({1'b1, fy_a});
    end

    // ---- product boundary
    logic                   sgn_p1, nan_p1, inf_p1, zer_p1, vld_p1;
    logic signed [EW-1:0]   esum_p1;
    logic [PW-1:0]          prod_p1;
    logic [2:0]             rm_p1;
    logic [TAG_W-1:0]       tag_p1;

    generate
        if (STAGES >= 3) begin : g_p1_reg
            always_ff @(posedge clk) begin
                if (rst)     vld_p1 <= 1'b0;
                else if (en) vld_p1 <= vld_p0;
            end
            always_ff @(posedge clk) begin
                if (en && vld_p0) begin
                    sgn_p1  <= sgn_a;
                    nan_p1  <= nan_a;
                    inf_p1  <= inf_a;
                    zer_p1  <= zer_a;
                    esum_p1 <= esum_a;
                    prod_p1 <= prod_a;
                    rm_p1   <= rm_p0;
                    tag_p1  <= tag_p0;
                end
            end
        end else begin : g_p1_wire
            assign vld_p1  = vld_p0;
            assign sgn_p1  = sgn_a;
            assign nan_p1  = nan_a;
            assign inf_p1  = inf_a;
            assign zer_p1  = zer_a;
            assign esum_p1 = esum_a;
            assign prod_p1 = prod_a;
            assign rm_p1   = rm_p0;
            assign tag_p1  = tag_p0;
        end
    endgenerate

    logic                   norm_n_b, guard_b, sticky_b;
    logic [PW-2:0]          shifted_b;
    logic [FRC_W-1:0]       frac_b;
    logic signed [EW-1:0]   exp_b;

    // The product of two hidden-one mantissas is in [1,4); drop the leading one.
    always_comb begin
        norm_n_b  = prod_p1[PW-1];
        shifted_b = norm_n_b ? prod_p1[PW-2:0] : {prod_p1[PW-3:0], 1'b0};
        frac_b    = shifted_b[PW-2 -: FRC_W];
        guard_b   = shifted_b[PW-2-FRC_W];
        sticky_b  = |shifted_b[PW-3-FRC_W:0];
        exp_b     = esum_p1 + $signed({{(EW-1){1'b0}}, norm_n_b});
    end

    // ---- normalise boundary
    logic                   sgn_p2, nan_p2, inf_p2, zer_p2, vld_p2;
    logic                   guard_p2, sticky_p2;
    logic signed [EW-1:0]   exp_p2;
    logic [FRC_W-1:0]       frac_p2;
    logic [2:0]             rm_p2;
    logic [TAG_W-1:0]       tag_p2;

    generate
        if (STAGES >= 2) begin : g_p2_reg
            always_ff @(posedge clk) begin
                if (rst)     vld_p2 <= 1'b0;
                else if (en) vld_p2 <= vld_p1;
            end
            always_ff @(posedge clk) begin
                if (en && vld_p1) begin
                    sgn_p2    <= sgn_p1;
                    nan_p2    <= nan_p1;
                    inf_p2    <= inf_p1;
                    zer_p2    <= zer_p1;
                    guard_p2  <= guard_b;
                    sticky_p2 <= sticky_b;
                    exp_p2    <= exp_b;
                    frac_p2   <= frac_b;
                    rm_p2     <= rm_p1;
                    tag_p2    <= tag_p1;
                end
            end
        end else begin : g_p2_wire
            assign vld_p2    = vld_p1;
            assign sgn_p2    = sgn_p1;
            assign nan_p2    = nan_p1;
            assign inf_p2    = inf_p1;
            assign zer_p2    = zer_p1;
            assign guard_p2  = guard_b;
            assign sticky_p2 = sticky_b;
            assign exp_p2    = exp_b;
            assign frac_p2   = frac_b;
            assign rm_p2     = rm_p1;
            assign tag_p2    = tag_p1;
        end
    endgenerate

    logic                   inc_c;
    logic [FRC_W:0]         frac_r_c;
    logic signed [EW-1:0]   exp_c;
    logic [W+1:0]           sat_c;
    logic [W-1:0]           z_c;
    logic                   ovrf_c, udrf_c, zer_c, inf_c, nan_c;

    // Rounding carry-out leaves an all-zero fraction, so only the exponent bumps.
    always_comb begin
        inc_c    = round_inc(rm_p2, sgn_p2, frac_p2[0], guard_p2, sticky_p2);
        frac_r_c = {1'b0, frac_p2} + {{FRC_W{1'b0}}, inc_c};
        exp_c    = exp_p2 + $signed({{(EW-1){1'b0}}, frac_r_c[FRC_W]});
        sat_c    = saturate(exp_c, sgn_p2, frac_r_c[FRC_W-1:0]);
        z_c      = sat_c[W-1:0];
        ovrf_c   = sat_c[W+1];
        udrf_c   = sat_c[W];
        inf_c    = sat_c[W+1];
        zer_c    = sat_c[W];
        nan_c    = 1'b0;
        if (nan_p2) begin
            z_c    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRC_W-1){1'b0}}};
            {ovrf_c, udrf_c, zer_c, inf_c, nan_c} = 5'b00001;
        end else if (inf_p2) begin
            z_c    = {sgn_p2, {EXP_W{1'b1}}, {FRC_W{1'b0}}};
            {ovrf_c, udrf_c, zer_c, inf_c, nan_c} = 5'b00010;
        end else if (zer_p2) begin
            z_c    = {sgn_p2, {(EXP_W + FRC_W){1'b0}}};
            {ovrf_c, udrf_c, zer_c, inf_c, nan_c} = 5'b00100;
        end
    end

    // ---- result boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            fp_Z      <= '0;
            out_tag   <= '0;
            {ovrf, udrf, zer, inf, nan} <= 5'b00000;
        end else if (en) begin
            out_valid <= vld_p2;
            if (vld_p2) begin
                fp_Z    <= z_c;
                out_tag <= tag_p2;
                {ovrf, udrf, zer, inf, nan} <= {ovrf_c, udrf_c, zer_c, inf_c, nan_c};
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Bench for fp_mul_pipe: directed corner cases, backpressure, random stream
// against an integer-arithmetic reference, and a half-precision 1-stage build.
module tb_fp_mul_pipe;
    localparam int TAG_W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, out_valid, out_ready;
    logic [31:0]      fp_X, fp_Y, fp_Z;
    logic [2:0]       r_mode;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic             ovrf, udrf, zer, inf, nan;

    logic             h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [15:0]      h_fp_X, h_fp_Y, h_fp_Z;
    logic [2:0]       h_r_mode;
    logic [TAG_W-1:0] h_in_tag, h_out_tag;
    logic             h_ovrf, h_udrf, h_zer, h_inf, h_nan;

    fp_mul_pipe u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fp_X(fp_X), .fp_Y(fp_Y), .r_mode(r_mode), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .fp_Z(fp_Z), .out_tag(out_tag),
        .ovrf(ovrf), .udrf(udrf), .zer(zer), .inf(inf), .nan(nan)
    );

    fp_mul_pipe #(.EXP_W(5), .FRC_W(10), .STAGES(1), .TAG_W(TAG_W)) u_dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .fp_X(h_fp_X), .fp_Y(h_fp_Y), .r_mode(h_r_mode), .in_tag(h_in_tag),
        .out_valid(h_out_valid), .out_ready(h_out_ready), .fp_Z(h_fp_Z), .out_tag(h_out_tag),
        .ovrf(h_ovrf), .udrf(h_udrf), .zer(h_zer), .inf(h_inf), .nan(h_nan)
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer product, then round to 24 significant bits.
    // Returns {ovrf, udrf, zer, inf, nan, word}.
    function automatic logic [36:0] ref_mul(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] rm);
        logic s, xz, yz, xi, yi, xn, yn, up;
        int ex, ey, e, sh;
        longint unsigned m, kept, rem, half;
        s  = x[31] ^ y[31];
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        xz = (ex == 0);   yz = (ey == 0);
        xi = (ex == 255) && (x[22:0] == 0);
        yi = (ey == 255) && (y[22:0] == 0);
        xn = (ex == 255) && (x[22:0] != 0);
        yn = (ey == 255) && (y[22:0] != 0);
        if (xn || yn || (xi && yz) || (yi && xz)) return {5'b00001, 32'h7FC00000};
        if (xi || yi) return {5'b00010, s, 8'hFF, 23'h0};
        if (xz || yz) return {5'b00100, s, 31'h0};
        m = (64'h800000 | 64'(x[22:0])) * (64'h800000 | 64'(y[22:0]));
        e = ex + ey - 127;
        if (m >= (64'd1 << 47)) begin sh = 24; e++; end
        else sh = 23;
        kept = m >> sh;
        rem  = m - (kept << sh);
        half = 64'd1 << (sh - 1);
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = s && (rem != 0);
            3'd3:    up = !s && (rem != 0);
            3'd4:    up = (rem >= half);
            default: up = (rem > half) || ((rem == half) && kept[0]);
        endcase
        kept = kept + 64'(up);
        if (kept == (64'd1 << 24)) begin kept = kept >> 1; e++; end
        if (e >= 255) return {5'b10010, s, 8'hFF, 23'h0};
        if (e <= 0)   return {5'b01100, s, 31'h0};
        return {5'b00000, s, 8'(e), kept[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        int sel;
        logic [7:0] e;
        logic [22:0] f;
        sel = $urandom_range(0, 15);
        f   = 23'($urandom);
        if ($urandom_range(0, 7) == 0) f = '0;
        if ($urandom_range(0, 7) == 0) f = '1;
        case (sel)
            0:       e = 8'd0;
            1:       e = 8'd255;
            2, 3:    e = 8'($urandom_range(1, 70));
            4, 5:    e = 8'($urandom_range(190, 254));
            default: e = 8'($urandom_range(90, 165));
        endcase
        return {1'($urandom), e, f};
    endfunction

    function automatic logic [41:0] grab(input bit hsel);
        if (hsel) return {h_out_valid, h_out_tag, h_ovrf, h_udrf, h_zer, h_inf, h_nan, 16'h0, h_fp_Z};
        return {out_valid, out_tag, ovrf, udrf, zer, inf, nan, fp_Z};
    endfunction

    task automatic run_one(input bit hsel, input logic [31:0] x, input logic [31:0] y,
                           input logic [2:0] rm, input logic [31:0] ez, input logic [4:0] ef,
                           input string nm);
        int lat;
        logic [41:0] o;
        @(negedge clk);
        if (hsel) begin
            h_in_valid = 1'b1; h_fp_X = x[15:0]; h_fp_Y = y[15:0]; h_r_mode = rm; h_in_tag = 4'hA;
        end else begin
            in_valid = 1'b1; fp_X = x; fp_Y = y; r_mode = rm; in_tag = 4'h5;
        end
        out_ready = 1'b1; h_out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; h_in_valid = 1'b0;
        lat = 1;
        o = grab(hsel);
        while (!o[41] && lat < 20) begin
            @(negedge clk);
            lat++;
            o = grab(hsel);
        end
        check_val({nm, "_lat"}, 64'(lat), hsel ? 64'd1 : 64'd3);
        check_val({nm, "_z"}, 64'(o[31:0]), 64'(ez));
        check_val({nm, "_flags"}, 64'(o[36:32]), 64'(ef));
        check_val({nm, "_tag"}, 64'(o[40:37]), hsel ? 64'hA : 64'h5);
    endtask

    task automatic run_stream(input int nbeats, input bit bp);
        logic [31:0] ox, oy, prev_z;
        logic [2:0]  orm;
        logic [36:0] r;
        logic [31:0] ez_q[$];
        logic [4:0]  ef_q[$];
        logic [TAG_W-1:0] et_q[$];
        int sent, got, cyc;
        bit have_op, prev_stall;
        sent = 0; got = 0; cyc = 0; have_op = 0; prev_stall = 0; prev_z = '0;
        ox = '0; oy = '0; orm = '0;
        while (got < nbeats && cyc < 3000) begin
            @(negedge clk);
            if (!have_op && sent < nbeats) begin
                ox = rand_op(); oy = rand_op(); orm = 3'($urandom_range(0, 7)); have_op = 1;
            end
            in_valid  = have_op && (bp || $urandom_range(0, 3) != 0);
            fp_X = ox; fp_Y = oy; r_mode = orm; in_tag = TAG_W'(sent);
            out_ready = bp ? !(cyc >= 2 && cyc <= 8) : ($urandom_range(0, 2) != 0);
            #1;
            if (prev_stall) begin
                check_val("hold_valid", 64'(out_valid), 64'd1);
                check_val("hold_z", 64'(fp_Z), 64'(prev_z));
            end
            check_val("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
            if (in_valid && in_ready) begin
                r = ref_mul(ox, oy, orm);
                ez_q.push_back(r[31:0]); ef_q.push_back(r[36:32]); et_q.push_back(TAG_W'(sent));
                sent++;
                have_op = 0;
            end
            if (out_valid && out_ready) begin
                if (ez_q.size() == 0) check_val("spurious_out", 64'(out_valid), 64'd0);
                else begin
                    check_val("stream_z", 64'(fp_Z), 64'(ez_q.pop_front()));
                    check_val("stream_flags", 64'({ovrf, udrf, zer, inf, nan}), 64'(ef_q.pop_front()));
                    check_val("stream_tag", 64'(out_tag), 64'(et_q.pop_front()));
                    got++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_z     = fp_Z;
            cyc++;
        end
        check_val("stream_count", 64'(got), 64'(nbeats));
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; out_ready = 1'b1; fp_X = '0; fp_Y = '0; r_mode = '0; in_tag = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b1; h_fp_X = '0; h_fp_Y = '0; h_r_mode = '0; h_in_tag = '0;
        repeat (3) @(negedge clk);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_z", 64'(fp_Z), 64'd0);
        check_val("rst_flags", 64'({ovrf, udrf, zer, inf, nan}), 64'd0);
        check_val("rst_tag", 64'(out_tag), 64'd0);
        rst = 1'b0;
        #1;
        check_val("rst_in_ready", 64'(in_ready), 64'd1);

        run_one(0, 32'h40400000, 32'h40400000, 3'b001, 32'h41100000, 5'b00000, "three_sq");
        run_one(0, 32'h7F800000, 32'h00000000, 3'b000, 32'h7FC00000, 5'b00001, "inf_x_zero");
        run_one(0, 32'h7F800000, 32'hC0000000, 3'b000, 32'hFF800000, 5'b00010, "inf_x_neg");
        run_one(0, 32'h7F000000, 32'h40000000, 3'b001, 32'h7F800000, 5'b10010, "ovf_rtz");
        run_one(0, 32'hFF000000, 32'h40000000, 3'b011, 32'hFF800000, 5'b10010, "ovf_rup_neg");
        run_one(0, 32'h20000000, 32'h1F800000, 3'b000, 32'h00000000, 5'b01100, "udf");
        run_one(0, 32'h3F800001, 32'h3FC00000, 3'b000, 32'h3FC00002, 5'b00000, "tie_rne");
        run_one(0, 32'h3F800001, 32'h3FC00000, 3'b001, 32'h3FC00001, 5'b00000, "tie_rtz");
        run_one(0, 32'h3F800001, 32'h3FC00000, 3'b100, 32'h3FC00002, 5'b00000, "tie_rmm");
        run_one(0, 32'h3F800001, 32'h3FC00000, 3'b010, 32'h3FC00001, 5'b00000, "tie_rdn");
        run_one(0, 32'hBF800001, 32'h3FC00000, 3'b010, 32'hBFC00002, 5'b00000, "tie_rdn_neg");
        run_one(0, 32'h3F800001, 32'h3FC00000, 3'b111, 32'h3FC00002, 5'b00000, "tie_mode7");
        run_one(0, 32'h80400000, 32'h40000000, 3'b000, 32'h80000000, 5'b00100, "subnorm");
        run_one(0, 32'h00400000, 32'h7F800000, 3'b000, 32'h7FC00000, 5'b00001, "subn_x_inf");
        run_one(0, 32'hFFC00001, 32'h3F800000, 3'b000, 32'h7FC00000, 5'b00001, "nan_in");
        run_one(1, 32'h3C00, 32'h4000, 3'b000, 32'h4000, 5'b00000, "h_one_two");
        run_one(1, 32'h3E00, 32'h3E00, 3'b000, 32'h4080, 5'b00000, "h_sq");
        run_one(1, 32'h7BFF, 32'h7BFF, 3'b000, 32'h7C00, 5'b10010, "h_ovf");

        run_stream(5, 1'b1);
        run_stream(300, 1'b0);

        @(negedge clk);
        in_valid = 1'b1; fp_X = 32'h3F800000; fp_Y = 32'h3F800000; r_mode = '0; in_tag = 4'h9;
        out_ready = 1'b1;
        h_in_valid = 1'b1; h_fp_X = 16'h3C00; h_fp_Y = 16'h3C00; h_r_mode = '0; h_in_tag = 4'h9;
        h_out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; h_in_valid = 1'b0; rst = 1'b1;
        check_val("h_before_rst", 64'(h_out_valid), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("midrst_valid", 64'(out_valid), 64'd0);
        check_val("midrst_h_valid", 64'(h_out_valid), 64'd0);
        check_val("midrst_h_ready", 64'(h_in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_val("midrst_drop", 64'(out_valid), 64'd0);
            check_val("midrst_h_drop", 64'(h_out_valid), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
